// File: rtl/sw_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state type and default prescaler period.
package sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_e;

  localparam int unsigned DIV_DEFAULT = 100000;

endpackage

// File: rtl/sw_ctrl_if.sv
// Button/mode inputs and digit-chain control outputs of the stopwatch controller.
interface sw_ctrl_if;

  logic btn_ss;
  logic btn_clr;
  logic mode_down;
  logic rco_all;
  logic ce;
  logic ud;
  logic cnt_clr;
  logic running;
  logic done;

  modport master (
    input  btn_ss, btn_clr, mode_down, rco_all,
    output ce, ud, cnt_clr, running, done
  );

  modport slave (
    output btn_ss, btn_clr, mode_down, rco_all,
    input  ce, ud, cnt_clr, running, done
  );

endinterface

// File: rtl/sw_btn_edge.sv
// 2-FF synchronizer followed by a rising-edge detector; one-cycle event per press.
module sw_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], btn};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  // sh_q[1] is the synchronized level, sh_q[2] its previous value
  assign ev = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch controller: prescaled count-enable tick, direction, start/stop/clear FSM
// and terminal-count stop for the cascaded BCD digit counters.
module sw_ctrl
  import sw_pkg::*;
#(
  parameter int unsigned DIV     = DIV_DEFAULT,
  parameter bit          WRAP_UP = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  sw_ctrl_if.master sw
);

  localparam int unsigned    PW         = $clog2(DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ce_q, ce_d;
  logic          ud_q, ud_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic ss_ev;
  logic clr_ev;
  logic tick;

  sw_btn_edge u_ss_edge  (.clk(clk), .rst(rst), .btn(sw.btn_ss),  .ev(ss_ev));
  sw_btn_edge u_clr_edge (.clk(clk), .rst(rst), .btn(sw.btn_clr), .ev(clr_ev));

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    ce_d      = 1'b0;
    ud_d      = ud_q;
    cnt_clr_d = 1'b0;

    // clear is tested first everywhere so it wins over a coincident start/stop
    case (state_q)
      ST_IDLE: begin
        ud_d    = ~sw.mode_down;
        presc_d = '0;
        if (clr_ev)     cnt_clr_d = 1'b1;
        else if (ss_ev) state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (clr_ev) begin
          cnt_clr_d = 1'b1;
          state_d   = ST_IDLE;
          presc_d   = '0;
        end else if (ss_ev) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          if (sw.rco_all && (!ud_q || !WRAP_UP)) state_d = ST_DONE;
          else                                    ce_d    = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (clr_ev) begin
          cnt_clr_d = 1'b1;
          state_d   = ST_IDLE;
          presc_d   = '0;
        end else if (ss_ev) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clr_ev) begin
          cnt_clr_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
    endcase

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      ce_q      <= 1'b0;
      ud_q      <= 1'b1;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ce_q      <= ce_d;
      ud_q      <= ud_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign sw.ce      = ce_q;
  assign sw.ud      = ud_q;
  assign sw.cnt_clr = cnt_clr_q;
  assign sw.running = running_q;
  assign sw.done    = done_q;

endmodule

// File: tb/tb_sw_ctrl.sv
// Scoreboard bench for sw_ctrl: expected ce / cnt_clr cycles are queued at stimulus time
// and matched against the DUT outputs; two instances cover WRAP_UP=0 and WRAP_UP=1.
module tb_sw_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_ss = 1'b0;
  logic btn_clr = 1'b0;
  logic mode_down = 1'b0;
  logic rco_all = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  int q_ce[$];
  int q_cew[$];
  int q_clr[$];

  sw_ctrl_if m_if ();
  sw_ctrl_if w_if ();

  assign m_if.btn_ss    = btn_ss;
  assign m_if.btn_clr   = btn_clr;
  assign m_if.mode_down = mode_down;
  assign m_if.rco_all   = rco_all;
  assign w_if.btn_ss    = btn_ss;
  assign w_if.btn_clr   = btn_clr;
  assign w_if.mode_down = mode_down;
  assign w_if.rco_all   = rco_all;

  sw_ctrl #(.DIV(4), .WRAP_UP(1'b0)) u_dut   (.clk(clk), .rst(rst), .sw(m_if));
  sw_ctrl #(.DIV(4), .WRAP_UP(1'b1)) u_dut_w (.clk(clk), .rst(rst), .sw(w_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_ce(input int c);
    q_ce.push_back(c);
    q_cew.push_back(c);
  endtask

  task automatic press_clr(output int p);
    p = cyc;
    btn_clr = 1'b1;
    q_clr.push_back(p + 3);
    repeat (2) @(negedge clk);
    btn_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (q_ce.size() != 0 && q_ce[0] < cyc) begin
        check("ce_missing", cyc, q_ce[0]);
        void'(q_ce.pop_front());
      end
      if (m_if.ce) begin
        if (q_ce.size() == 0) check("ce_unexpected", m_if.ce, 1'b0);
        else                  check("ce_time", cyc, q_ce.pop_front());
      end
      if (q_cew.size() != 0 && q_cew[0] < cyc) begin
        check("cew_missing", cyc, q_cew[0]);
        void'(q_cew.pop_front());
      end
      if (w_if.ce) begin
        if (q_cew.size() == 0) check("cew_unexpected", w_if.ce, 1'b0);
        else                   check("cew_time", cyc, q_cew.pop_front());
      end
      if (q_clr.size() != 0 && q_clr[0] < cyc) begin
        check("clr_missing", cyc, q_clr[0]);
        void'(q_clr.pop_front());
      end
      if (m_if.cnt_clr) begin
        if (q_clr.size() == 0) check("clr_unexpected", m_if.cnt_clr, 1'b0);
        else                   check("clr_time", cyc, q_clr.pop_front());
      end
      if (m_if.ce || m_if.cnt_clr) check("ce_clr_excl", m_if.ce & m_if.cnt_clr, 1'b0);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int p, e, q;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ce", m_if.ce, 1'b0);
    check("rst_ud", m_if.ud, 1'b1);
    check("rst_cnt_clr", m_if.cnt_clr, 1'b0);
    check("rst_running", m_if.running, 1'b0);
    check("rst_done", m_if.done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1: up count, tick every 4 clocks
    p = cyc; btn_ss = 1'b1; e = p + 3;
    push_ce(e + 4); push_ce(e + 8); push_ce(e + 12); push_ce(e + 16);
    wait_cyc(p + 2); btn_ss = 1'b0;
    wait_cyc(e - 1);
    check("t1_running_pre", m_if.running, 1'b0);
    wait_cyc(e);
    check("t1_running", m_if.running, 1'b1);
    check("t1_ud", m_if.ud, 1'b1);
    check("t1_done", m_if.done, 1'b0);
    wait_cyc(e + 14);
    press_clr(q);
    wait_cyc(q + 3);
    check("t1_clr_idle", m_if.running, 1'b0);
    wait_cyc(q + 6);

    // T2: pause after two prescaler counts, long hold, resume
    p = cyc; btn_ss = 1'b1; e = p + 3;
    wait_cyc(p + 2); btn_ss = 1'b0;
    wait_cyc(e); btn_ss = 1'b1;
    wait_cyc(e + 3);
    check("t2_paused", m_if.running, 1'b0);
    check("t2_paused_done", m_if.done, 1'b0);
    wait_cyc(e + 10);
    check("t2_hold_single_ev", m_if.running, 1'b0);
    btn_ss = 1'b0;
    wait_cyc(e + 14); btn_ss = 1'b1;
    push_ce(e + 19); push_ce(e + 23);
    wait_cyc(e + 16);
    check("t2_resume_pre", m_if.running, 1'b0);
    btn_ss = 1'b0;
    wait_cyc(e + 17);
    check("t2_resumed", m_if.running, 1'b1);
    wait_cyc(e + 24);
    press_clr(q);
    wait_cyc(q + 3);
    check("t2_clr_idle", m_if.running, 1'b0);
    wait_cyc(q + 6);

    // T3: down count reaching zero on the third tick
    mode_down = 1'b1;
    @(negedge clk);
    p = cyc; btn_ss = 1'b1; e = p + 3;
    push_ce(e + 4); push_ce(e + 8);
    wait_cyc(p + 2); btn_ss = 1'b0;
    wait_cyc(e);
    check("t3_ud_down", m_if.ud, 1'b0);
    wait_cyc(e + 9); rco_all = 1'b1;
    wait_cyc(e + 12);
    check("t3_done", m_if.done, 1'b1);
    check("t3_running", m_if.running, 1'b0);
    check("t3_wrap_done", w_if.done, 1'b1);
    wait_cyc(e + 13); mode_down = 1'b0; btn_ss = 1'b1;
    wait_cyc(e + 15); btn_ss = 1'b0;
    wait_cyc(e + 18);
    check("t3_ss_ignored", m_if.done, 1'b1);
    check("t3_ud_frozen", m_if.ud, 1'b0);
    rco_all = 1'b0;
    press_clr(q);
    wait_cyc(q + 3);
    check("t3_clr_done", m_if.done, 1'b0);
    check("t3_clr_running", m_if.running, 1'b0);
    wait_cyc(q + 5);
    check("t3_ud_idle", m_if.ud, 1'b1);
    wait_cyc(q + 6);

    // T4: up count at terminal value, stop vs wrap
    p = cyc; btn_ss = 1'b1; e = p + 3;
    q_cew.push_back(e + 4); q_cew.push_back(e + 8);
    wait_cyc(p + 2); btn_ss = 1'b0;
    wait_cyc(e + 1); rco_all = 1'b1;
    wait_cyc(e + 4);
    check("t4_nowrap_done", m_if.done, 1'b1);
    check("t4_nowrap_running", m_if.running, 1'b0);
    check("t4_wrap_running", w_if.running, 1'b1);
    check("t4_wrap_done", w_if.done, 1'b0);
    wait_cyc(e + 5); rco_all = 1'b0;
    wait_cyc(e + 7);
    press_clr(q);
    wait_cyc(q + 3);
    check("t4_wrap_idle", w_if.running, 1'b0);
    check("t4_nowrap_idle", m_if.done, 1'b0);
    wait_cyc(q + 6);

    // T5: start/stop and clear in the same cycle on a tick edge
    p = cyc; btn_ss = 1'b1; e = p + 3;
    push_ce(e + 4);
    wait_cyc(p + 2); btn_ss = 1'b0;
    wait_cyc(e + 5); btn_ss = 1'b1; btn_clr = 1'b1;
    q_clr.push_back(e + 8);
    wait_cyc(e + 7);
    check("t5_running_pre", m_if.running, 1'b1);
    wait_cyc(e + 8);
    check("t5_clear_wins", m_if.running, 1'b0);
    check("t5_not_done", m_if.done, 1'b0);
    wait_cyc(e + 9); btn_ss = 1'b0; btn_clr = 1'b0;
    wait_cyc(e + 14);
    check("t5_stay_idle", m_if.running, 1'b0);

    // T6: asynchronous reset one cycle before a tick
    p = cyc; btn_ss = 1'b1; e = p + 3;
    push_ce(e + 4);
    wait_cyc(p + 2); btn_ss = 1'b0;
    wait_cyc(e + 7);
    check("t6_running_pre", m_if.running, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_running", m_if.running, 1'b0);
    check("t6_async_ce", m_if.ce, 1'b0);
    check("t6_async_done", m_if.done, 1'b0);
    check("t6_async_ud", m_if.ud, 1'b1);
    check("t6_async_wrap_running", w_if.running, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p = cyc;
    wait_cyc(p + 20);
    check("t6_idle_after", m_if.running, 1'b0);

    check("ce_queue_empty", q_ce.size(), 0);
    check("cew_queue_empty", q_cew.size(), 0);
    check("clr_queue_empty", q_clr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
